// File: rtl/irq_controller.sv
// Interrupt controller: gathers NSRC async request lines into a registered IRQ and FIQ,
// with per-source level/edge mode, latched pending bits and an 8-bit host register bus.
module irq_controller #(
  parameter int unsigned NSRC        = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_MODE  = 8'h00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  output logic            fiq,
  input  logic            cs,
  input  logic [2:0]      addr,
  input  logic            re,
  input  logic            we,
  input  logic [7:0]      wdata,
  output logic [7:0]      rdata
);

  localparam logic [NSRC-1:0] ModeInit = RESET_MODE[NSRC-1:0];

  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] s, s_d_q, rise;
  logic [NSRC-1:0] latch_q, latch_d;
  logic [NSRC-1:0] irq_en_q, irq_en_d;
  logic [NSRC-1:0] fiq_en_q, fiq_en_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic            soft_irq_q, soft_irq_d;
  logic            irq_q, fiq_q;
  logic [NSRC-1:0] pending, irq_act, fiq_act;
  logic [2:0]      vec_idx;
  logic            vec_none;
  logic            wr, wr_pend, wr_ien, wr_fen, wr_mode, wr_ctrl, soft_rst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      s_d_q <= '0;
    end else begin
      sync_q[0] <= src;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      s_d_q <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  assign wr       = cs & we;
  assign wr_pend  = wr && (addr == 3'd1);
  assign wr_ien   = wr && (addr == 3'd2);
  assign wr_fen   = wr && (addr == 3'd3);
  assign wr_mode  = wr && (addr == 3'd4);
  assign wr_ctrl  = wr && (addr == 3'd5);
  assign soft_rst = wr_ctrl & wdata[7];

  assign pending = (mode_q & latch_q) | (~mode_q & s);
  assign fiq_act = pending & fiq_en_q;
  assign irq_act = pending & irq_en_q & ~fiq_en_q;

  always_comb begin
    latch_d    = latch_q;
    mode_d     = mode_q;
    irq_en_d   = irq_en_q;
    fiq_en_d   = fiq_en_q;
    soft_irq_d = soft_irq_q;
    if (wr_pend) latch_d = latch_d & ~wdata[NSRC-1:0];
    if (wr_mode) begin
      mode_d  = wdata[NSRC-1:0];
      latch_d = latch_d & wdata[NSRC-1:0];
    end
    if (wr_ien) irq_en_d = wdata[NSRC-1:0];
    if (wr_fen) fiq_en_d = wdata[NSRC-1:0];
    if (wr_ctrl) soft_irq_d = wdata[0];
    // A fresh edge beats a same-cycle W1C; soft reset beats everything.
    latch_d = latch_d | (rise & mode_d);
    if (soft_rst) begin
      latch_d    = '0;
      mode_d     = ModeInit;
      irq_en_d   = '0;
      fiq_en_d   = '0;
      soft_irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_q    <= '0;
      mode_q     <= ModeInit;
      irq_en_q   <= '0;
      fiq_en_q   <= '0;
      soft_irq_q <= 1'b0;
      irq_q      <= 1'b0;
      fiq_q      <= 1'b0;
    end else begin
      latch_q    <= latch_d;
      mode_q     <= mode_d;
      irq_en_q   <= irq_en_d;
      fiq_en_q   <= fiq_en_d;
      soft_irq_q <= soft_irq_d;
      irq_q      <= (|irq_act) | soft_irq_q;
      fiq_q      <= |fiq_act;
    end
  end

  assign irq = irq_q;
  assign fiq = fiq_q;

  always_comb begin
    vec_idx  = 3'd0;
    vec_none = ~|irq_act;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (irq_act[i]) vec_idx = 3'(i);
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (cs && re) begin
      case (addr)
        3'd0:    rdata = 8'(s);
        3'd1:    rdata = 8'(pending);
        3'd2:    rdata = 8'(irq_en_q);
        3'd3:    rdata = 8'(fiq_en_q);
        3'd4:    rdata = 8'(mode_q);
        3'd5:    rdata = {7'b0, soft_irq_q};
        3'd6:    rdata = {vec_none, 4'b0, vec_idx};
        default: rdata = 8'(fiq_act);
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model built on a history of sampled inputs.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src;
  logic       irq, fiq;
  logic       cs, re, we;
  logic [2:0] addr;
  logic [7:0] wdata, rdata;

  int n_tests = 0;
  int n_fail  = 0;

  irq_controller #(
    .NSRC       (8),
    .SYNC_STAGES(2),
    .RESET_MODE (8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .src  (src),
    .irq  (irq),
    .fiq  (fiq),
    .cs   (cs),
    .addr (addr),
    .re   (re),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Model state: hist holds the last two clock-sampled src values, oldest first.
  logic [7:0] hist[$];
  logic [7:0] m_sd, m_latch, m_ien, m_fen, m_mode;
  logic       m_soft, m_irq, m_fiq;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_pending();
    return (m_mode & m_latch) | (~m_mode & hist[0]);
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a);
    logic [7:0] p, ia;
    p  = m_pending();
    ia = p & m_ien & ~m_fen;
    case (a)
      3'd0: return hist[0];
      3'd1: return p;
      3'd2: return m_ien;
      3'd3: return m_fen;
      3'd4: return m_mode;
      3'd5: return {7'b0, m_soft};
      3'd6: begin
        if (ia == 8'h00) return 8'h80;
        for (int i = 0; i < 8; i++) if (ia[i]) return 8'(i);
        return 8'hff;
      end
      default: return p & m_fen;
    endcase
  endfunction

  task automatic model_reset();
    hist = '{8'h00, 8'h00};
    m_sd = 0; m_latch = 0; m_ien = 0; m_fen = 0; m_mode = 8'h00;
    m_soft = 0; m_irq = 0; m_fiq = 0;
  endtask

  // Applies one rising edge using the bus and src values present before it.
  task automatic model_edge();
    logic [7:0] s, p, new_mode;
    s = hist[0];
    p = m_pending();
    m_irq = ((p & m_ien & ~m_fen) != 8'h00) || m_soft;
    m_fiq = (p & m_fen) != 8'h00;
    new_mode = m_mode;
    if (cs && we) begin
      if (addr == 3'd1) m_latch &= ~wdata;
      if (addr == 3'd2) m_ien = wdata;
      if (addr == 3'd3) m_fen = wdata;
      if (addr == 3'd4) begin new_mode = wdata; m_latch &= wdata; end
      if (addr == 3'd5) m_soft = wdata[0];
    end
    m_latch |= s & ~m_sd & new_mode;
    m_mode = new_mode;
    if (cs && we && addr == 3'd5 && wdata[7]) begin
      m_latch = 0; m_mode = 8'h00; m_ien = 0; m_fen = 0; m_soft = 0;
    end
    m_sd = s;
    hist.push_back(src);
    void'(hist.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("irq", {7'b0, irq}, {7'b0, m_irq});
    check("fiq", {7'b0, fiq}, {7'b0, m_fiq});
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1; we = 1; addr = a; wdata = d;
    tick();
    cs = 0; we = 0;
  endtask

  task automatic rd(input logic [2:0] a, input string tag);
    cs = 1; re = 1; addr = a;
    #1;
    check(tag, rdata, m_read(a));
    cs = 0; re = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 8; a++) rd(3'(a), $sformatf("%s_reg%0d", tag, a));
  endtask

  initial begin
    reset = 1; src = 0; cs = 0; re = 0; we = 0; addr = 0; wdata = 0;
    model_reset();
    #12 reset = 0;
    ticks(2);
    read_all("reset");
    rd(3'd6, "reset_vector");
    check("reset_vector_const", rdata, 8'h80);

    // Level source on bit 3: three-clock latency both ways.
    wr(3'd2, 8'h08);
    src[3] = 1;
    ticks(2);
    check("lvl_not_yet", {7'b0, irq}, 8'h00);
    tick();
    check("lvl_rise", {7'b0, irq}, 8'h01);
    rd(3'd6, "lvl_vector");
    src[3] = 0;
    ticks(3);
    check("lvl_fall", {7'b0, irq}, 8'h00);

    // Edge source on bit 0: one-clock pulse, latch, W1C, coincident edge.
    wr(3'd4, 8'h01);
    wr(3'd2, 8'h01);
    src[0] = 1;
    tick();
    src[0] = 0;
    ticks(2);
    check("edge_not_yet", {7'b0, irq}, 8'h00);
    tick();
    check("edge_rise", {7'b0, irq}, 8'h01);
    ticks(5);
    rd(3'd1, "edge_pending");
    wr(3'd1, 8'h01);
    tick();
    check("w1c_low", {7'b0, irq}, 8'h00);
    src[0] = 1;
    ticks(2);
    src[0] = 0;
    wr(3'd1, 8'h01);
    rd(3'd1, "w1c_vs_edge");
    ticks(2);
    check("w1c_vs_edge_irq", {7'b0, irq}, 8'h01);
    wr(3'd4, 8'h00);
    ticks(2);

    // FIQ precedence on source 7.
    wr(3'd2, 8'h80);
    wr(3'd3, 8'h80);
    src[7] = 1;
    ticks(4);
    rd(3'd7, "fiq_active");
    rd(3'd6, "fiq_vector");
    wr(3'd3, 8'h00);
    tick();
    check("fiq_to_irq", {7'b0, irq}, 8'h01);
    src[7] = 0;
    ticks(4);

    // Priority between sources 2 and 5.
    wr(3'd2, 8'h24);
    src = 8'h24;
    ticks(3);
    rd(3'd6, "prio_2");
    wr(3'd2, 8'h20);
    rd(3'd6, "prio_5");
    src = 0;
    ticks(3);

    // Soft IRQ, then soft reset.
    wr(3'd2, 8'hff);
    wr(3'd5, 8'h01);
    tick();
    check("soft_irq", {7'b0, irq}, 8'h01);
    wr(3'd5, 8'h81);
    read_all("softrst");
    tick();
    check("softrst_irq", {7'b0, irq}, 8'h00);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) src = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        addr  = 3'($urandom_range(1, 5));
        wdata = 8'($urandom);
        if (addr == 3'd5 && $urandom_range(0, 7) != 0) wdata[7] = 1'b0;
        cs = 1; we = 1;
      end
      tick();
      cs = 0; we = 0;
      rd(3'($urandom_range(0, 7)), "rand_read");
    end

    // Asynchronous reset pulse between edges.
    wr(3'd2, 8'hff);
    wr(3'd4, 8'h0f);
    src = 8'hff;
    ticks(4);
    reset = 1;
    #2;
    model_reset();
    check("arst_irq", {7'b0, irq}, 8'h00);
    check("arst_fiq", {7'b0, fiq}, 8'h00);
    read_all("arst");
    reset = 0;
    src = 0;
    ticks(3);
    read_all("post_arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
